// File: rtl/eth_intr_if.sv
// Register bus between the host CPU and the Ethernet interrupt controller.
// The host drives the strobes; the controller returns registered read data.
interface eth_intr_if;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (
    output reg_wr_en,
    output reg_rd_en,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_wr_en,
    input  reg_rd_en,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/eth_intr_ctrl.sv
// Ethernet MAC interrupt controller: sticky W1C status, mask and
// count/timeout coalescing of events into one level interrupt.
module eth_intr_ctrl #(
  parameter int NUM_SRC = 7,
  parameter int CNT_W   = 8,
  parameter int TMR_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_pulse,
  eth_intr_if.slave          bus,
  output logic               intr
);

  localparam logic [1:0] A_SRC = 2'd0;
  localparam logic [1:0] A_MSK = 2'd1;
  localparam logic [1:0] A_CNT = 2'd2;
  localparam logic [1:0] A_TMR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ASSERT
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] status;
  logic [NUM_SRC-1:0] mask;
  logic [CNT_W-1:0]   coal_cnt;
  logic [TMR_W-1:0]   coal_tmr;
  logic [CNT_W-1:0]   evt_cnt;
  logic [TMR_W-1:0]   tmr;

  logic               wr_src;
  logic               wr_msk;
  logic               wr_cnt;
  logic               wr_tmr;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] status_nxt;
  logic               pend;
  logic               new_evt;
  logic [CNT_W-1:0]   cnt_eff;
  logic               tmr_on;
  logic [CNT_W-1:0]   cnt_inc;
  logic [TMR_W-1:0]   tmr_dec;
  logic [31:0]        rd_mux;
  logic               unused;

  assign unused = &{1'b0, bus.reg_wdata[31:TMR_W]};

  assign wr_src = bus.reg_wr_en && (bus.reg_addr == A_SRC);
  assign wr_msk = bus.reg_wr_en && (bus.reg_addr == A_MSK);
  assign wr_cnt = bus.reg_wr_en && (bus.reg_addr == A_CNT);
  assign wr_tmr = bus.reg_wr_en && (bus.reg_addr == A_TMR);

  // A set on the same cycle as a clear wins
  assign w1c        = wr_src ? bus.reg_wdata[NUM_SRC-1:0] : '0;
  assign status_nxt = (status & ~w1c) | src_pulse;

  assign pend    = |(status & mask);
  assign new_evt = |(src_pulse & mask);

  assign cnt_eff = (coal_cnt == '0) ? CNT_W'(1) : coal_cnt;
  assign tmr_on  = (coal_tmr != '0);

  assign cnt_inc = (new_evt && (evt_cnt != '1)) ?
                   evt_cnt + CNT_W'(1) : evt_cnt;
  assign tmr_dec = (tmr_on && (tmr != '0)) ?
                   tmr - TMR_W'(1) : tmr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status   <= '0;
      mask     <= '0;
      coal_cnt <= CNT_W'(1);
      coal_tmr <= '0;
    end else begin
      status <= status_nxt;
      if (wr_msk) mask     <= bus.reg_wdata[NUM_SRC-1:0];
      if (wr_cnt) coal_cnt <= bus.reg_wdata[CNT_W-1:0];
      if (wr_tmr) coal_tmr <= bus.reg_wdata[TMR_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      evt_cnt <= '0;
      tmr     <= '0;
      intr    <= 1'b0;
    end else begin
      intr <= (state == S_ASSERT) && pend;
      unique case (state)
        S_IDLE: begin
          if (new_evt) begin
            if (cnt_eff <= CNT_W'(1)) begin
              state <= S_ASSERT;
            end else begin
              state   <= S_ACCUM;
              evt_cnt <= CNT_W'(1);
              tmr     <= coal_tmr;
            end
          end else if (pend) begin
            // Latched event exposed by an unmask
            state <= S_ASSERT;
          end
        end
        S_ACCUM: begin
          evt_cnt <= cnt_inc;
          tmr     <= tmr_dec;
          if (!pend && !new_evt) begin
            state   <= S_IDLE;
            evt_cnt <= '0;
            tmr     <= '0;
          end else if ((cnt_inc >= cnt_eff) ||
                       (tmr_on && (tmr_dec == '0))) begin
            state   <= S_ASSERT;
            evt_cnt <= '0;
            tmr     <= '0;
          end
        end
        S_ASSERT: begin
          if (!pend) state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          evt_cnt <= '0;
          tmr     <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (bus.reg_addr)
      A_SRC: rd_mux = {{(32-NUM_SRC){1'b0}}, status};
      A_MSK: rd_mux = {{(32-NUM_SRC){1'b0}}, mask};
      A_CNT: rd_mux = {{(32-CNT_W){1'b0}}, coal_cnt};
      A_TMR: rd_mux = {{(32-TMR_W){1'b0}}, coal_tmr};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.reg_rdata <= '0;
    end else begin
      bus.reg_rdata <= bus.reg_rd_en ? rd_mux : 32'd0;
    end
  end

endmodule

// File: doc/eth_intr_ctrl.md
Name: eth_intr_ctrl

Overview:
Interrupt controller and coalescer for the Ethernet MAC subsystem. It latches per-source event pulses (TX/RX done, TX/RX error, busy, control frames) into a sticky, write-1-to-clear status register and applies a software mask. It drives the single level interrupt line `intr`, which the environment monitors through the Ethernet reset/interrupt interface. A count threshold and a timeout coalesce bursts of events into one interrupt assertion.

Parameters:
- NUM_SRC, 7: number of interrupt sources. Bit order: 0 TXB, 1 TXE, 2 RXB, 3 RXE, 4 BUSY, 5 TXC, 6 RXC.
- CNT_W, 8: width of the coalescing event counter and threshold.
- TMR_W, 16: width of the coalescing timeout counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- src_pulse  in  NUM_SRC  one-cycle event strobes from the MAC.
- reg_wr_en  in  1  register write strobe.
- reg_rd_en  in  1  register read strobe.
- reg_addr  in  2  register select: 0 INT_SOURCE, 1 INT_MASK, 2 COAL_CNT, 3 COAL_TMR.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, registered.
- intr  out  1  level interrupt to host, registered.

Behaviour:
- Reset values:
  - status = 0, mask = 0, COAL_CNT = 1, COAL_TMR = 0.
  - evt_cnt = 0, tmr = 0, state = IDLE.
  - intr = 0, reg_rdata = 0.
- Register access:
  - INT_SOURCE: write 1 clears the bit; write 0 leaves it unchanged.
  - INT_MASK, COAL_CNT[CNT_W-1:0], COAL_TMR[TMR_W-1:0]: read/write. Unused high bits read 0.
- Status update each cycle: status_next = (status & ~w1c) | src_pulse. If a set and a clear hit the same bit in the same cycle, the set wins.
- Masked pending: pend = |(status & mask), computed from registered status.
- new_evt = |(src_pulse & mask).
- Reads: reg_rdata is valid the cycle after reg_rd_en and shows the register value before any same-cycle write. reg_rdata is 0 in cycles with no read.
- Coalescing FSM states: IDLE, ACCUM, ASSERT.
  - IDLE, intr=0:
    - new_evt and COAL_CNT <= 1 → ASSERT.
    - new_evt otherwise → ACCUM, with evt_cnt = 1 and tmr = COAL_TMR.
  - ACCUM, intr=0:
    - evt_cnt increments (saturating at 2^CNT_W-1) on each cycle with new_evt.
    - tmr decrements toward 0 when COAL_TMR != 0.
    - Exit to ASSERT when evt_cnt >= COAL_CNT, or when COAL_TMR != 0 and tmr reaches 0.
    - Exit to IDLE (counters cleared) when !pend and !new_evt, i.e. software cleared or masked everything.
  - ASSERT, intr=1:
    - → IDLE when !pend, including a mask write of 0.
    - New events while asserted only set status bits.
- intr is registered: it rises the cycle after the FSM enters ASSERT, which is 2 cycles after the triggering src_pulse when the threshold is 1. It falls the cycle after pend drops.
- COAL_TMR = 0 disables the timeout, so ACCUM waits on the count only. COAL_CNT = 0 behaves as 1.
- Events arriving while the source is masked stay latched in status. Unmasking later raises pend but does not itself count as new_evt. In IDLE, a nonzero pend with no new_evt goes → ASSERT, so a latched event is never lost.
- Config writes during ACCUM take effect on the next comparison; tmr is not reloaded.
- rst asserted mid-operation: all state returns to reset values immediately and intr deasserts asynchronously.

Test Plan:
- Reset check: assert rst mid-ACCUM → intr = 0, all registers read reset values (INT_MASK 0x0, COAL_CNT 0x1, COAL_TMR 0x0); pulses with mask 0 leave intr low while INT_SOURCE shows the bits.
- Basic interrupt: mask = 0x7F, COAL_CNT = 1, pulse bit 2 (RXB) → intr high 2 cycles later, INT_SOURCE reads 0x04; write 0x04 to INT_SOURCE → intr low 1 cycle later.
- Count coalescing: COAL_CNT = 4, COAL_TMR = 0, four RXB pulses 10 cycles apart → intr stays low until the cycle after the 4th pulse is counted, then rises.
- Timeout coalescing: COAL_CNT = 8, COAL_TMR = 20, a single TXB pulse → intr rises about 21–22 cycles later; W1C 0x01 → intr falls.
- Simultaneous set and clear: TXE pulse in the same cycle as a W1C of 0x02 → bit 1 remains set and intr stays/returns high; partial clear of 0x05 with only 0x04 written → intr stays high until 0x01 is also cleared.
- Masked-then-unmasked: mask = 0, BUSY pulse; then write mask 0x10 → intr asserts; write mask 0 → intr deasserts while INT_SOURCE still reads 0x10.
